// File: rtl/feature_map_collector_if.sv
// Stream bundle for feature_map_collector: conv/pool input side, serial drain side
// and status flags.
interface feature_map_collector_if #(
    parameter int unsigned NumberOfK          = 4,
    parameter int unsigned ProcessingElements = 2,
    parameter int unsigned BitSize            = 32
);
    logic [NumberOfK-1:0]                         in_valid;
    logic [ProcessingElements-1:0][BitSize-1:0]   in_data;
    logic                                         in_set_done;
    logic                                         out_ready;
    logic                                         out_valid;
    logic [BitSize-1:0]                           out_data;
    logic                                         out_last;
    logic                                         busy;
    logic                                         err_overflow;
    logic                                         err_short;

    // Producer/consumer side (drives the conv results, accepts the drained stream)
    modport master (
        output in_valid, in_data, in_set_done, out_ready,
        input  out_valid, out_data, out_last, busy, err_overflow, err_short
    );

    // Collector side
    modport slave (
        input  in_valid, in_data, in_set_done, out_ready,
        output out_valid, out_data, out_last, busy, err_overflow, err_short
    );
endinterface

// File: rtl/feature_map_collector.sv
// Collects per-kernel pooled feature maps from a non-stallable conv/pool stage and
// drains the whole frame, kernel-major, as one valid/ready word stream.
module feature_map_collector #(
    parameter int unsigned NumberOfK          = 4,
    parameter int unsigned ProcessingElements = 2,
    parameter int unsigned BitSize            = 32,
    parameter int unsigned ImageWidth         = 4
) (
    input logic                    clk,
    input logic                    res_n,
    feature_map_collector_if.slave bus
);
    localparam int unsigned P  = ImageWidth * ImageWidth;
    localparam int unsigned CW = $clog2(P + 1);
    localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned KW = (NumberOfK > 1) ? $clog2(NumberOfK) : 1;

    localparam logic [CW-1:0] PCnt  = CW'(P);
    localparam logic [PW-1:0] PLast = PW'(P - 1);
    localparam logic [KW-1:0] KLast = KW'(NumberOfK - 1);

    typedef enum logic [0:0] {StCollect, StDrain} state_e;

    state_e state_q, state_d;

    // Read side: kernel/pixel pointer of the next word to fetch into the output register
    logic [KW-1:0]      rk_q, rk_d;
    logic [PW-1:0]      rp_q, rp_d;
    logic               fetch_done_q, fetch_done_d;

    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [BitSize-1:0] out_data_q, out_data_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_short_q, err_short_d;

    logic                 collecting;
    logic                 clear_cnt;
    logic [NumberOfK-1:0] accept;
    logic [NumberOfK-1:0] drop;
    logic [NumberOfK-1:0] short_k;
    logic [BitSize-1:0]   rd_word [NumberOfK];

    assign collecting = (state_q == StCollect);

    for (genvar k = 0; k < NumberOfK; k++) begin : g_kernel
        logic [BitSize-1:0] bank [P];
        logic [CW-1:0]      wcnt_q;
        logic               full;

        assign full       = (wcnt_q == PCnt);
        assign accept[k]  = collecting && bus.in_valid[k] && !full;
        // Anything arriving while draining, or beyond P pixels, is lost
        assign drop[k]    = bus.in_valid[k] && (!collecting || full);
        // Count as it will be after this cycle's write, so a same-cycle last pixel counts
        assign short_k[k] = ((wcnt_q + CW'(accept[k])) != PCnt);
        assign rd_word[k] = bank[rp_q];

        // Per-kernel write counter; cleared when the frame finishes draining
        always_ff @(posedge clk) begin
            if (!res_n) begin
                wcnt_q <= '0;
            end else if (clear_cnt) begin
                wcnt_q <= '0;
            end else if (accept[k]) begin
                wcnt_q <= wcnt_q + CW'(1);
            end
        end

        // Kernel storage; contents are don't-care after reset so it is not reset
        always_ff @(posedge clk) begin
            if (accept[k]) begin
                bank[wcnt_q[PW-1:0]] <= bus.in_data[k % ProcessingElements];
            end
        end
    end

    // Next-state logic: collect/drain control, prefetching output register, sticky errors
    always_comb begin
        state_d      = state_q;
        rk_d         = rk_q;
        rp_d         = rp_q;
        fetch_done_d = fetch_done_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        err_ovf_d    = err_ovf_q | (|drop);
        err_short_d  = err_short_q;
        clear_cnt    = 1'b0;

        unique case (state_q)
            StCollect: begin
                if (bus.in_set_done) begin
                    state_d = StDrain;
                    if (|short_k) begin
                        err_short_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_valid_q && bus.out_ready && out_last_q) begin
                    state_d      = StCollect;
                    out_valid_d  = 1'b0;
                    out_last_d   = 1'b0;
                    rk_d         = '0;
                    rp_d         = '0;
                    fetch_done_d = 1'b0;
                    clear_cnt    = 1'b1;
                end else if (!fetch_done_q && (!out_valid_q || bus.out_ready)) begin
                    // Refill the output register in the same cycle it empties: no bubbles
                    out_valid_d = 1'b1;
                    out_data_d  = rd_word[rk_q];
                    out_last_d  = (rk_q == KLast) && (rp_q == PLast);
                    if (rp_q == PLast) begin
                        rp_d = '0;
                        if (rk_q == KLast) begin
                            fetch_done_d = 1'b1;
                        end else begin
                            rk_d = rk_q + KW'(1);
                        end
                    end else begin
                        rp_d = rp_q + PW'(1);
                    end
                end else if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // State and control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q      <= StCollect;
            rk_q         <= '0;
            rp_q         <= '0;
            fetch_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            err_ovf_q    <= 1'b0;
            err_short_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rk_q         <= rk_d;
            rp_q         <= rp_d;
            fetch_done_q <= fetch_done_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            err_ovf_q    <= err_ovf_d;
            err_short_q  <= err_short_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_data     = out_data_q;
    assign bus.busy         = (state_q == StDrain);
    assign bus.err_overflow = err_ovf_q;
    assign bus.err_short    = err_short_q;

endmodule
